lsu: RTL and testbench

- Load/store unit directly downstream of the execute-stage ALU in the rv32i core.
- Takes the ALU result as the effective address, runs one Wishbone-classic bus cycle per load or store, and stalls the pipeline until the cycle completes.
- Byte/halfword loads are aligned and sign/zero-extended before writeback.
- Misaligned accesses, illegal ops, bus errors and timeouts are reported as one-cycle faults.

---
 rtl/lsu_if.sv | 54 +++++
 rtl/lsu.sv | 240 ++++++++++++++++++++++++
 tb/tb_lsu.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// ----------------------------------------------------------------------------
// lsu_if: signal bundle between the EX stage, the load/store unit and the
// Wishbone-classic data bus.
//
// Handshake: the EX stage presents a request (ex_valid with ex_mem_read or
// ex_mem_write) and must hold it while stall=1. The op retires on the
// cycle where wb_valid or fault pulses (stall=0). On the bus side, the LSU
// holds cyc/stb and all request fields stable until the slave answers with
// bus_ack or bus_err for one cycle.
//
// Modports:
//   master : load/store unit side (drives stall, results and the bus request)
//   slave  : environment side (EX stage and bus slave)
// dbg_state exposes the LSU FSM state (0 IDLE, 1 REQ, 2 DONE).
// ----------------------------------------------------------------------------
interface lsu_if;
   logic        ex_valid;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic        stall;
   logic        wb_valid;
   logic [31:0] wb_rdata;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        bus_cyc;
   logic        bus_stb;
   logic        bus_we;
   logic [31:0] bus_adr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_dat_o;
   logic [31:0] bus_dat_i;
   logic        bus_ack;
   logic        bus_err;
   logic [1:0]  dbg_state;

   modport master (
      input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr, ex_wdata,
      input  bus_dat_i, bus_ack, bus_err,
      output stall, wb_valid, wb_rdata, fault, fault_cause,
      output bus_cyc, bus_stb, bus_we, bus_adr, bus_sel, bus_dat_o,
      output dbg_state
   );

   modport slave (
      output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr, ex_wdata,
      output bus_dat_i, bus_ack, bus_err,
      input  stall, wb_valid, wb_rdata, fault, fault_cause,
      input  bus_cyc, bus_stb, bus_we, bus_adr, bus_sel, bus_dat_o,
      input  dbg_state
   );
endinterface

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu: load/store unit behind the rv32i execute stage.
//
// Takes the ALU result as effective address, runs one Wishbone-classic cycle
// per load/store and stalls the pipeline until it completes. Sub-word loads
// are aligned and sign/zero extended. Misaligned accesses, illegal ops and
// bus errors retire as a one-cycle fault pulse with a cause code.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   io     : lsu_if.master (EX request, stall, writeback, fault, Wishbone bus)
//
// Parameter TIMEOUT_CYCLES (1..65535): REQ cycles without ack/err before the
// cycle is aborted. Only active when the macro LSU_TIMEOUT_EN is defined;
// otherwise REQ waits indefinitely.
//
// Fault causes: 01 misaligned, 10 bus error/timeout, 11 illegal op.
// ----------------------------------------------------------------------------
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic  clk,
   input  logic  reset,
   lsu_if.master io
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("lsu: TIMEOUT_CYCLES out of range 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] dat_o_q, dat_o_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic        wb_valid_q, wb_valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic [1:0]  cause_q, cause_d;

`ifdef LSU_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_q, tmo_d;
`endif

   logic        req;
   logic        illegal;
   logic        misaligned;
   logic [3:0]  lane_sel;
   logic [31:0] lane_dat;

   // Shift the addressed lane down to bit 0, then extend per funct3.
   function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] d);
      logic [31:0] s;
      s = d >> {off, 3'b000};
      case (f3)
         3'b000:  load_extend = {{24{s[7]}}, s[7:0]};
         3'b001:  load_extend = {{16{s[15]}}, s[15:0]};
         3'b100:  load_extend = {24'd0, s[7:0]};
         3'b101:  load_extend = {16'd0, s[15:0]};
         default: load_extend = s;
      endcase
   endfunction

   assign req = io.ex_valid & (io.ex_mem_read | io.ex_mem_write);

   always_comb begin
      illegal = 1'b0;
      if (io.ex_mem_read & io.ex_mem_write) begin
         illegal = 1'b1;
      end else if (io.ex_mem_read) begin
         illegal = (io.ex_funct3 == 3'b011) | (io.ex_funct3 == 3'b110) |
                   (io.ex_funct3 == 3'b111);
      end else if (io.ex_mem_write) begin
         illegal = (io.ex_funct3 >= 3'b011);
      end
   end

   always_comb begin
      misaligned = 1'b0;
      lane_sel   = 4'b1111;
      lane_dat   = io.ex_wdata;
      case (io.ex_funct3[1:0])
         2'b00: begin
            lane_sel = 4'b0001 << io.ex_addr[1:0];
            lane_dat = {4{io.ex_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = io.ex_addr[0];
            lane_sel   = io.ex_addr[1] ? 4'b1100 : 4'b0011;
            lane_dat   = {2{io.ex_wdata[15:0]}};
         end
         default: begin
            misaligned = (io.ex_addr[1:0] != 2'b00);
         end
      endcase
   end

   // Next-state and next-output logic. Result pulses default low so they
   // last exactly the DONE cycle; bus request fields default to hold.
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      we_d       = we_q;
      adr_d      = adr_q;
      sel_d      = sel_q;
      dat_o_d    = dat_o_q;
      f3_d       = f3_q;
      off_d      = off_q;
      wb_valid_d = 1'b0;
      rdata_d    = 32'd0;
      fault_d    = 1'b0;
      cause_d    = 2'b00;
`ifdef LSU_TIMEOUT_EN
      tmo_d      = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               if (illegal) begin
                  fault_d = 1'b1;
                  cause_d = 2'b11;
                  state_d = DONE;
               end else if (misaligned) begin
                  fault_d = 1'b1;
                  cause_d = 2'b01;
                  state_d = DONE;
               end else begin
                  cyc_d   = 1'b1;
                  we_d    = io.ex_mem_write;
                  adr_d   = {io.ex_addr[31:2], 2'b00};
                  sel_d   = lane_sel;
                  dat_o_d = io.ex_mem_write ? lane_dat : 32'd0;
                  f3_d    = io.ex_funct3;
                  off_d   = io.ex_addr[1:0];
                  state_d = REQ;
`ifdef LSU_TIMEOUT_EN
                  tmo_d   = 16'd0;
`endif
               end
            end
         end
         REQ: begin
            // err outranks ack; an ack outranks timeout expiry.
            if (io.bus_err) begin
               cyc_d   = 1'b0;
               fault_d = 1'b1;
               cause_d = 2'b10;
               state_d = DONE;
            end else if (io.bus_ack) begin
               cyc_d      = 1'b0;
               wb_valid_d = 1'b1;
               rdata_d    = we_q ? 32'd0 : load_extend(f3_q, off_q, io.bus_dat_i);
               state_d    = DONE;
            end
`ifdef LSU_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               cyc_d   = 1'b0;
               fault_d = 1'b1;
               cause_d = 2'b10;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
`endif
         end
         DONE: begin
            // EX inputs are ignored here; the pipeline advances on this edge.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= 32'd0;
         sel_q      <= 4'd0;
         dat_o_q    <= 32'd0;
         f3_q       <= 3'd0;
         off_q      <= 2'd0;
         wb_valid_q <= 1'b0;
         rdata_q    <= 32'd0;
         fault_q    <= 1'b0;
         cause_q    <= 2'd0;
`ifdef LSU_TIMEOUT_EN
         tmo_q      <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         sel_q      <= sel_d;
         dat_o_q    <= dat_o_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         wb_valid_q <= wb_valid_d;
         rdata_q    <= rdata_d;
         fault_q    <= fault_d;
         cause_q    <= cause_d;
`ifdef LSU_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
      end
   end

   // Stall is combinational in IDLE so the accept cycle already holds EX;
   // it is forced low while reset is asserted.
   assign io.stall       = ~reset & (((state_q == IDLE) & req) | (state_q == REQ));
   assign io.wb_valid    = wb_valid_q;
   assign io.wb_rdata    = rdata_q;
   assign io.fault       = fault_q;
   assign io.fault_cause = cause_q;
   assign io.bus_cyc     = cyc_q;
   assign io.bus_stb     = cyc_q;
   assign io.bus_we      = we_q;
   assign io.bus_adr     = adr_q;
   assign io.bus_sel     = sel_q;
   assign io.bus_dat_o   = dat_o_q;
   assign io.dbg_state   = state_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

`ifdef LSU_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif

   typedef struct packed {
      logic        fault;
      logic [1:0]  cause;
      logic [3:0]  sel;
      logic [31:0] dat_o;
      logic [31:0] rdata;
   } exp_t;

   logic        clk;
   logic        reset;
   int          checks;
   int          errors;
   logic [31:0] exp_q[$];

   lsu_if io ();

   lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Derived from the access rules: size in bytes, alignment by modulo,
   // lanes as a mask shifted by the byte offset, loads by shift/mask/extend.
   function automatic exp_t model(input logic r, input logic w, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] din, input logic err);
      exp_t e;
      int size;
      int o;
      longint unsigned v;
      longint unsigned m;
      e = '0;
      size = 1 << f3[1:0];
      o = int'(addr[1:0]);
      if ((r && w) || (r && (f3 == 3'd3 || f3 >= 3'd6)) || (w && f3 >= 3'd3)) begin
         e.fault = 1'b1;
         e.cause = 2'b11;
      end else if (o % size != 0) begin
         e.fault = 1'b1;
         e.cause = 2'b01;
      end else begin
         e.sel = 4'(((1 << size) - 1) << o);
         if (w) begin
            if (size == 1)      e.dat_o = {24'd0, wdata[7:0]} * 32'h0101_0101;
            else if (size == 2) e.dat_o = {16'd0, wdata[15:0]} * 32'h0001_0001;
            else                e.dat_o = wdata;
         end
         if (err) begin
            e.fault = 1'b1;
            e.cause = 2'b10;
         end else if (r) begin
            v = {32'd0, din};
            v = v >> (8 * o);
            m = (64'd1 << (8 * size)) - 64'd1;
            v = v & m;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~m;
            e.rdata = v[31:0];
         end
      end
      return e;
   endfunction

   // ---------------- driver + checker for one op ----------------
   // wait_n: REQ cycles before the slave answers (-1: never answers).
   task automatic run_op(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] din, input int wait_n, input logic err,
                         output logic [31:0] o_rdata, output logic [3:0] o_sel,
                         output logic [31:0] o_dat, output int o_stall,
                         output int o_lat, output logic [1:0] o_cause);
      exp_t        e;
      int          n;
      int          reqc;
      int          stall_n;
      int          lat;
      int          exp_req;
      logic        seen_cyc;
      logic        done_f;
      logic        held_ok;
      logic [68:0] first_bus;
      logic        got_wb;
      logic        got_fault;
      logic [1:0]  got_cause;
      logic [31:0] got_rdata;
      logic [31:0] exp_rd;
      e = model(r, w, f3, addr, wdata, din, err);
      if (wait_n < 0 && !e.fault) begin
         e.fault = 1'b1;
         e.cause = 2'b10;
      end
      if (e.fault) e.rdata = 32'd0;
      exp_q.push_back(e.rdata);
      if (e.fault && e.cause != 2'b10) exp_req = 0;
      else if (wait_n < 0)             exp_req = TMO;
      else                             exp_req = wait_n + 1;
      n = 0; reqc = 0; stall_n = 0; lat = 0;
      seen_cyc = 1'b0; done_f = 1'b0; held_ok = 1'b1; first_bus = '0;
      got_wb = 1'b0; got_fault = 1'b0; got_cause = 2'b00; got_rdata = 32'd0;
      @(negedge clk);
      io.ex_valid = 1'b1; io.ex_mem_read = r; io.ex_mem_write = w;
      io.ex_funct3 = f3; io.ex_addr = addr; io.ex_wdata = wdata;
      while (!done_f && n < 300) begin
         #1;
         if (io.stall) stall_n++;
         if (io.bus_cyc) begin
            if (!seen_cyc) first_bus = {io.bus_we, io.bus_adr, io.bus_sel, io.bus_dat_o};
            else if ({io.bus_we, io.bus_adr, io.bus_sel, io.bus_dat_o} !== first_bus) held_ok = 1'b0;
            seen_cyc = 1'b1;
            reqc++;
            if (wait_n >= 0 && reqc == wait_n + 1) begin
               io.bus_ack = 1'b1; io.bus_err = err; io.bus_dat_i = din;
            end
         end
         if (io.wb_valid || io.fault) begin
            done_f = 1'b1; lat = n + 1;
            got_wb = io.wb_valid; got_fault = io.fault;
            got_cause = io.fault_cause; got_rdata = io.wb_rdata;
            io.ex_valid = 1'b0;
         end
         @(negedge clk);
         io.bus_ack = 1'b0; io.bus_err = 1'b0; io.bus_dat_i = $urandom;
         n++;
      end
      io.ex_valid = 1'b0;
      exp_rd = exp_q.pop_front();
      checks++;
      if (done_f !== 1'b1) begin
         errors++; $display("FAIL op_complete got %0d exp 1 (addr %h f3 %0d)", done_f, addr, f3);
      end
      checks++;
      if ({got_wb, got_fault, got_cause} !== {~e.fault, e.fault, e.cause}) begin
         errors++; $display("FAIL op_result got wb=%0d f=%0d c=%0d exp wb=%0d f=%0d c=%0d (addr %h f3 %0d r%0d w%0d)",
                            got_wb, got_fault, got_cause, ~e.fault, e.fault, e.cause, addr, f3, r, w);
      end
      checks++;
      if (got_rdata !== exp_rd) begin
         errors++; $display("FAIL op_rdata got %h exp %h (addr %h f3 %0d)", got_rdata, exp_rd, addr, f3);
      end
      checks++;
      if (reqc !== exp_req) begin
         errors++; $display("FAIL op_req_cycles got %0d exp %0d", reqc, exp_req);
      end
      checks++;
      if (stall_n !== 1 + exp_req || lat !== 2 + exp_req) begin
         errors++; $display("FAIL op_timing got stall=%0d lat=%0d exp stall=%0d lat=%0d",
                            stall_n, lat, 1 + exp_req, 2 + exp_req);
      end
      if (exp_req > 0) begin
         checks++;
         if (first_bus !== {w, addr[31:2], 2'b00, e.sel, e.dat_o} || !held_ok) begin
            errors++; $display("FAIL op_bus got %h held=%0d exp %h", first_bus, held_ok,
                               {w, addr[31:2], 2'b00, e.sel, e.dat_o});
         end
      end
      #1;
      checks++;
      if ({io.wb_valid, io.fault, io.stall, io.bus_cyc} !== 4'b0000) begin
         errors++; $display("FAIL op_pulse_end got wb=%0d f=%0d st=%0d cyc=%0d exp 0",
                            io.wb_valid, io.fault, io.stall, io.bus_cyc);
      end
      o_rdata = got_rdata; o_sel = first_bus[35:32]; o_dat = first_bus[31:0];
      o_stall = stall_n; o_lat = lat; o_cause = got_cause;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      io.ex_valid = 1'b0; io.ex_mem_read = 1'b0; io.ex_mem_write = 1'b0;
      io.ex_funct3 = 3'd0; io.ex_addr = 32'd0; io.ex_wdata = 32'd0;
      io.bus_dat_i = 32'd0; io.bus_ack = 1'b0; io.bus_err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({io.stall, io.wb_valid, io.wb_rdata, io.fault, io.fault_cause, io.bus_cyc, io.bus_stb,
           io.bus_we, io.bus_adr, io.bus_sel, io.bus_dat_o} !== '0) begin
         errors++; $display("FAIL reset_outputs got cyc=%0d adr=%h sel=%h dat=%h wb=%0d f=%0d exp all 0",
                            io.bus_cyc, io.bus_adr, io.bus_sel, io.bus_dat_o, io.wb_valid, io.fault);
      end
      reset = 1'b0;
   endtask

   task automatic test_lw_zero_wait();
      logic [31:0] rd, dat; logic [3:0] sel; int st, lat; logic [1:0] cs;
      run_op(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (rd !== 32'hDEAD_BEEF || sel !== 4'b1111) begin
         errors++; $display("FAIL lw_data got %h sel %b exp deadbeef sel 1111", rd, sel);
      end
      checks++;
      if (lat !== 3 || st !== 2) begin
         errors++; $display("FAIL lw_latency got lat=%0d stall=%0d exp 3/2", lat, st);
      end
   endtask

   task automatic test_byte_loads();
      logic [31:0] rd, dat; logic [3:0] sel; int st, lat; logic [1:0] cs;
      run_op(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'd0, 32'h80FF_FF7F, 0, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (rd !== 32'hFFFF_FF80 || sel !== 4'b1000) begin
         errors++; $display("FAIL lb_sign got %h sel %b exp ffffff80 sel 1000", rd, sel);
      end
      run_op(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'd0, 32'h80FF_FF7F, 1, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (rd !== 32'h0000_0080) begin
         errors++; $display("FAIL lbu_zero got %h exp 00000080", rd);
      end
   endtask

   task automatic test_store_half();
      logic [31:0] rd, dat; logic [3:0] sel; int st, lat; logic [1:0] cs;
      run_op(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h5555_AAAA, 3, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (dat !== 32'hABCD_ABCD || sel !== 4'b1100 || rd !== 32'd0) begin
         errors++; $display("FAIL sh_lanes got dat=%h sel=%b rd=%h exp abcdabcd 1100 0", dat, sel, rd);
      end
      checks++;
      if (st !== 5) begin
         errors++; $display("FAIL sh_stall got %0d exp 5", st);
      end
   endtask

   task automatic test_faults();
      logic [31:0] rd, dat; logic [3:0] sel; int st, lat; logic [1:0] cs;
      run_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 0, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (cs !== 2'b01 || lat !== 2 || st !== 1) begin
         errors++; $display("FAIL misaligned got cause=%b lat=%0d st=%0d exp 01/2/1", cs, lat, st);
      end
      run_op(1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'd0, 32'd0, 0, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (cs !== 2'b11) begin
         errors++; $display("FAIL illegal_f3 got cause=%b exp 11", cs);
      end
      run_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h1111_2222, 1, 1'b1, rd, sel, dat, st, lat, cs);
      checks++;
      if (cs !== 2'b10 || rd !== 32'd0) begin
         errors++; $display("FAIL bus_err got cause=%b rd=%h exp 10/0", cs, rd);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      @(negedge clk);
      io.ex_valid = 1'b1; io.ex_mem_read = 1'b1; io.ex_mem_write = 1'b0;
      io.ex_funct3 = 3'b010; io.ex_addr = 32'h0000_0100;
      k = 0;
      #1;
      while (!io.bus_cyc && k < 5) begin
         @(negedge clk); #1; k++;
      end
      checks++;
      if (io.bus_cyc !== 1'b1) begin
         errors++; $display("FAIL reset_mid_start got cyc=%0d exp 1", io.bus_cyc);
      end
      reset = 1'b1; io.ex_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({io.bus_cyc, io.bus_stb, io.stall} !== 3'b000) begin
         errors++; $display("FAIL reset_mid_drop got cyc=%0d stb=%0d st=%0d exp 0", io.bus_cyc, io.bus_stb, io.stall);
      end
      @(negedge clk);
      reset = 1'b0; io.bus_ack = 1'b1; io.bus_dat_i = $urandom;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({io.wb_valid, io.fault} !== 2'b00) begin
            errors++; $display("FAIL late_ack got wb=%0d f=%0d exp 0", io.wb_valid, io.fault);
         end
      end
      @(negedge clk);
      io.bus_ack = 1'b0;
   endtask

`ifdef LSU_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] rd, dat; logic [3:0] sel; int st, lat; logic [1:0] cs;
      run_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'd0, -1, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (cs !== 2'b10 || st !== 5) begin
         errors++; $display("FAIL timeout got cause=%b st=%0d exp 10/5", cs, st);
      end
      run_op(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'd0, 32'hCAFE_F00D, 0, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (rd !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL after_timeout got %h exp cafef00d", rd);
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] rd, dat; logic [3:0] sel; int st, lat; logic [1:0] cs;
      logic r, w; int k;
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 9);
         r = (k <= 5);
         w = (k == 0) || (k >= 6);
         run_op(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0), rd, sel, dat, st, lat, cs);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, dat; logic [3:0] sel; int st, lat; logic [1:0] cs;
      run_op(1'b0, 1'b1, 3'b000, 32'h0000_0401, 32'h0000_00A5, 32'd0, 0, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (dat !== 32'hA5A5_A5A5 || sel !== 4'b0010) begin
         errors++; $display("FAIL sb_lanes got dat=%h sel=%b exp a5a5a5a5 0010", dat, sel);
      end
      run_op(1'b1, 1'b0, 3'b001, 32'h0000_0402, 32'd0, 32'h8001_7FFF, 0, 1'b0, rd, sel, dat, st, lat, cs);
      checks++;
      if (rd !== 32'hFFFF_8001) begin
         errors++; $display("FAIL lh_upper got %h exp ffff8001", rd);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_lw_zero_wait();
      test_byte_loads();
      test_store_half();
      test_faults();
      test_reset_mid();
`ifdef LSU_TIMEOUT_EN
      test_timeout();
`endif
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
